// File: rtl/core_dispatch_scheduler_if.sv
// Request/result channel between a client and the core dispatch scheduler.
// The client side takes the master modport, the scheduler takes slave.
interface core_dispatch_scheduler_if #(
    parameter int DATA = 256
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [DATA-1:0] req_a;
    logic [DATA-1:0] req_b;
    logic            req_err;
    logic            res_valid;
    logic            res_ready;
    logic [DATA-1:0] res_data;
    logic [4:0]      res_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, req_err, res_valid, res_data, res_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, req_err, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/core_dispatch_scheduler.sv
// Dispatch scheduler: accepts one operation at a time, issues it to Core1
// (Mul/Xor) or Core2 (Sqr/Inv/Red) through their input/command FIFOs, and
// returns results strictly in issue order using a small {core, tag} queue.
module core_dispatch_scheduler #(
    parameter int DATA      = 256,
    parameter int ORD_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    core_dispatch_scheduler_if.slave bus,
    output logic              wr_en_Core1_Inp,
    output logic [2*DATA-1:0] Data_in_Core1_Inp,
    input  logic              In_Busy_Core1_Inp,
    output logic              wr_en_Core1_Cmd,
    output logic [7:0]        Data_in_Core1_Cmd,
    input  logic              In_Busy_Core1_Cmd,
    output logic              rd_en_Core1_Output,
    input  logic [DATA-1:0]   Data_Out_Core1_Output,
    input  logic              Out_Busy_Core1_Output,
    output logic              wr_en_Core2_Inp,
    output logic [DATA-1:0]   Data_in_Core2_Inp,
    input  logic              In_Busy_Core2_Inp,
    output logic              wr_en_Core2_Cmd,
    output logic [7:0]        Data_in_Core2_Cmd,
    input  logic              In_Busy_Core2_Cmd,
    output logic              rd_en_Core2_Output,
    input  logic [DATA-1:0]   Data_Out_Core2_Output,
    input  logic              Out_Busy_Core2_Output,
    output logic [3:0]        outstanding
);

    localparam int AW = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(ORD_DEPTH);

    // Opcodes 1..5 are legal; Mul and Xor go to Core1, the rest to Core2.
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_RED = 3'd5;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, WR = 2'd2} issue_state_t;
    typedef enum logic [1:0] {RIDLE = 2'd0, RD = 2'd1, HOLD = 2'd2} ret_state_t;

    issue_state_t    issue_state, issue_next;
    ret_state_t      ret_state, ret_next;

    logic            active_q;
    logic [2:0]      op_q;
    logic [DATA-1:0] a_q, b_q;
    logic            core_q;
    logic [4:0]      tag_q;
    logic            req_err_q;

    logic [5:0]      ord_mem [ORD_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, count;
    logic [5:0]      head;
    logic            head_core;
    logic [4:0]      head_tag;
    logic            head_empty;

    logic            cap_pending;
    logic            res_valid_q;
    logic [DATA-1:0] res_data_q;
    logic [4:0]      res_tag_q;

    logic            accept, req_legal, req_core, sel_busy;
    logic            push, pop, queue_full, queue_empty;

    assign count       = wr_ptr - rd_ptr;
    assign queue_full  = (count == DEPTH_P);
    assign queue_empty = (count == '0);
    assign outstanding = 4'(count);

    assign bus.req_ready = active_q && (issue_state == IDLE) && !queue_full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_legal     = (bus.req_op >= OP_MUL) && (bus.req_op <= OP_RED);
    assign req_core      = !((bus.req_op == OP_MUL) || (bus.req_op == OP_XOR));
    assign sel_busy      = core_q ? (In_Busy_Core2_Inp || In_Busy_Core2_Cmd)
                                  : (In_Busy_Core1_Inp || In_Busy_Core1_Cmd);

    assign push = (issue_state == WR);
    assign pop  = (ret_state == HOLD) && res_valid_q && bus.res_ready;

    assign wr_en_Core1_Inp   = push && !core_q;
    assign wr_en_Core1_Cmd   = push && !core_q;
    assign wr_en_Core2_Inp   = push && core_q;
    assign wr_en_Core2_Cmd   = push && core_q;
    assign Data_in_Core1_Inp = {a_q, b_q};
    assign Data_in_Core2_Inp = a_q;
    assign Data_in_Core1_Cmd = {tag_q, op_q};
    assign Data_in_Core2_Cmd = {tag_q, op_q};

    assign head       = ord_mem[rd_ptr[AW-1:0]];
    assign head_core  = head[5];
    assign head_tag   = head[4:0];
    assign head_empty = head_core ? Out_Busy_Core2_Output : Out_Busy_Core1_Output;

    assign rd_en_Core1_Output = (ret_state == RD) && !head_core;
    assign rd_en_Core2_Output = (ret_state == RD) && head_core;

    assign bus.req_err   = req_err_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;

    // Issue FSM next state: wait for both FIFOs of the chosen core to have room.
    always_comb begin
        issue_next = issue_state;
        case (issue_state)
            IDLE:    if (accept && req_legal) issue_next = WAIT;
            WAIT:    if (!sel_busy) issue_next = WR;
            WR:      issue_next = IDLE;
            default: issue_next = IDLE;
        endcase
    end

    // Issue state, latched request, tag counter and the illegal-opcode pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_state <= IDLE;
            active_q    <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            core_q      <= 1'b0;
            tag_q       <= '0;
            req_err_q   <= 1'b0;
        end else begin
            issue_state <= issue_next;
            active_q    <= 1'b1;
            req_err_q   <= accept && !req_legal;
            if (accept && req_legal) begin
                op_q   <= bus.req_op;
                a_q    <= bus.req_a;
                b_q    <= bus.req_b;
                core_q <= req_core;
            end
            if (push) begin
                tag_q <= tag_q + 5'd1;
            end
        end
    end

    // Order queue storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            ord_mem[wr_ptr[AW-1:0]] <= {core_q, tag_q};
        end
    end

    // Order queue pointers: push on issue write, pop on result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Return FSM next state: only the head core is ever read.
    always_comb begin
        ret_next = ret_state;
        case (ret_state)
            RIDLE:   if (!queue_empty && !head_empty) ret_next = RD;
            RD:      ret_next = HOLD;
            HOLD:    if (pop) ret_next = RIDLE;
            default: ret_next = RIDLE;
        endcase
    end

    // Return state and result register; data is captured one cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_state   <= RIDLE;
            cap_pending <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            ret_state   <= ret_next;
            cap_pending <= (ret_state == RD);
            if ((ret_state == HOLD) && cap_pending) begin
                res_data_q  <= head_core ? Data_Out_Core2_Output : Data_Out_Core1_Output;
                res_tag_q   <= head_tag;
                res_valid_q <= 1'b1;
            end else if (pop) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_dispatch_scheduler.sv
// Self-checking bench for core_dispatch_scheduler: expected FIFO writes and
// results are queued as requests are driven and compared as the DUT emits them.
module tb_core_dispatch_scheduler;

    localparam int DATA = 256;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_SQR = 3'd2;
    localparam logic [2:0] OP_INV = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_RED = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    core_dispatch_scheduler_if #(.DATA(DATA)) bus ();

    logic              wr_en_Core1_Inp, wr_en_Core1_Cmd, rd_en_Core1_Output;
    logic [2*DATA-1:0] Data_in_Core1_Inp;
    logic [7:0]        Data_in_Core1_Cmd;
    logic              In_Busy_Core1_Inp, In_Busy_Core1_Cmd, Out_Busy_Core1_Output;
    logic [DATA-1:0]   Data_Out_Core1_Output;
    logic              wr_en_Core2_Inp, wr_en_Core2_Cmd, rd_en_Core2_Output;
    logic [DATA-1:0]   Data_in_Core2_Inp;
    logic [7:0]        Data_in_Core2_Cmd;
    logic              In_Busy_Core2_Inp, In_Busy_Core2_Cmd, Out_Busy_Core2_Output;
    logic [DATA-1:0]   Data_Out_Core2_Output;
    logic [3:0]        outstanding;

    core_dispatch_scheduler #(.DATA(DATA), .ORD_DEPTH(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus                   (bus.slave),
        .wr_en_Core1_Inp       (wr_en_Core1_Inp),
        .Data_in_Core1_Inp     (Data_in_Core1_Inp),
        .In_Busy_Core1_Inp     (In_Busy_Core1_Inp),
        .wr_en_Core1_Cmd       (wr_en_Core1_Cmd),
        .Data_in_Core1_Cmd     (Data_in_Core1_Cmd),
        .In_Busy_Core1_Cmd     (In_Busy_Core1_Cmd),
        .rd_en_Core1_Output    (rd_en_Core1_Output),
        .Data_Out_Core1_Output (Data_Out_Core1_Output),
        .Out_Busy_Core1_Output (Out_Busy_Core1_Output),
        .wr_en_Core2_Inp       (wr_en_Core2_Inp),
        .Data_in_Core2_Inp     (Data_in_Core2_Inp),
        .In_Busy_Core2_Inp     (In_Busy_Core2_Inp),
        .wr_en_Core2_Cmd       (wr_en_Core2_Cmd),
        .Data_in_Core2_Cmd     (Data_in_Core2_Cmd),
        .In_Busy_Core2_Cmd     (In_Busy_Core2_Cmd),
        .rd_en_Core2_Output    (rd_en_Core2_Output),
        .Data_Out_Core2_Output (Data_Out_Core2_Output),
        .Out_Busy_Core2_Output (Out_Busy_Core2_Output),
        .outstanding           (outstanding)
    );

    typedef struct packed {
        logic              core;
        logic [2*DATA-1:0] data;
        logic [7:0]        cmd;
    } wr_t;

    typedef struct packed {
        logic            core;
        logic [4:0]      tag;
        logic [DATA-1:0] data;
    } res_t;

    wr_t             exp_wr[$];
    res_t            exp_res[$];
    logic [DATA-1:0] st1[$], st2[$], oq1[$], oq2[$];
    logic [4:0]      tb_tag;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    int acc_cyc = 0;
    int prev_acc_cyc = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    bit acc_seen, rd1_seen, rd2_seen, hold_pend;
    logic [DATA-1:0] hold_data;
    logic [4:0]      hold_tag;
    logic [7:0]      last_cmd;

    task automatic checkOutput(input string tag, input logic [2*DATA-1:0] got,
                               input logic [2*DATA-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic monitor();
        logic w1, w2;
        wr_t  e;
        res_t r;
        logic [2*DATA-1:0] d;
        logic [7:0] c;
        if (bus.req_valid && bus.req_ready) begin
            acc_seen     = 1'b1;
            prev_acc_cyc = acc_cyc;
            acc_cyc      = cyc;
        end
        if (bus.req_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        w1 = wr_en_Core1_Inp || wr_en_Core1_Cmd;
        w2 = wr_en_Core2_Inp || wr_en_Core2_Cmd;
        if (w1 || w2) begin
            checkOutput("wr_one_core", w1 && w2, 0);
            checkOutput("wr_inp_cmd_pair", w2 ? (wr_en_Core2_Inp ^ wr_en_Core2_Cmd)
                                              : (wr_en_Core1_Inp ^ wr_en_Core1_Cmd), 0);
            wr_cnt++;
            last_wr_cyc = cyc;
            d = w2 ? {{DATA{1'b0}}, Data_in_Core2_Inp} : Data_in_Core1_Inp;
            c = w2 ? Data_in_Core2_Cmd : Data_in_Core1_Cmd;
            last_cmd = c;
            if (exp_wr.size() == 0) begin
                checkOutput("wr_unexpected", 1, 0);
            end else begin
                e = exp_wr.pop_front();
                checkOutput("wr_core", w2, e.core);
                checkOutput("wr_data", d, e.data);
                checkOutput("wr_cmd", c, e.cmd);
            end
        end
        if (rd_en_Core1_Output || rd_en_Core2_Output) begin
            if (exp_res.size() == 0) checkOutput("rd_unexpected", 1, 0);
            else checkOutput("rd_head_core", rd_en_Core2_Output, exp_res[0].core);
            checkOutput("rd_nonempty", rd_en_Core2_Output ? Out_Busy_Core2_Output
                                                          : Out_Busy_Core1_Output, 0);
            rd1_seen = rd_en_Core1_Output;
            rd2_seen = rd_en_Core2_Output;
        end
        if (bus.res_valid) begin
            if (hold_pend) begin
                checkOutput("res_hold_data", bus.res_data, hold_data);
                checkOutput("res_hold_tag", bus.res_tag, hold_tag);
            end
            if (bus.res_ready) begin
                hold_pend = 1'b0;
                if (exp_res.size() == 0) begin
                    checkOutput("res_unexpected", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    checkOutput("res_tag", bus.res_tag, r.tag);
                    checkOutput("res_data", bus.res_data, r.data);
                end
            end else begin
                hold_pend = 1'b1;
                hold_data = bus.res_data;
                hold_tag  = bus.res_tag;
            end
        end else begin
            hold_pend = 1'b0;
        end
    endtask

    // One clock: observe at the falling edge, then model the output FIFOs after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rd1_seen && oq1.size() > 0) Data_Out_Core1_Output = oq1.pop_front();
        if (rd2_seen && oq2.size() > 0) Data_Out_Core2_Output = oq2.pop_front();
        rd1_seen = 1'b0;
        rd2_seen = 1'b0;
        Out_Busy_Core1_Output = (oq1.size() == 0);
        Out_Busy_Core2_Output = (oq2.size() == 0);
    endtask

    task automatic runCycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic releaseCore(input bit core);
        if (!core) begin
            while (st1.size() > 0) oq1.push_back(st1.pop_front());
        end else begin
            while (st2.size() > 0) oq2.push_back(st2.pop_front());
        end
        Out_Busy_Core1_Output = (oq1.size() == 0);
        Out_Busy_Core2_Output = (oq2.size() == 0);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [DATA-1:0] a,
                                 input logic [DATA-1:0] b, input logic [DATA-1:0] val,
                                 input bit rel);
        bit   legal, core;
        wr_t  e;
        res_t r;
        legal = (op >= OP_MUL) && (op <= OP_RED);
        core  = (op == OP_SQR) || (op == OP_INV) || (op == OP_RED);
        if (legal) begin
            e.core = core;
            e.data = core ? {{DATA{1'b0}}, a} : {a, b};
            e.cmd  = {tb_tag, op};
            exp_wr.push_back(e);
            r.core = core;
            r.tag  = tb_tag;
            r.data = val;
            exp_res.push_back(r);
            if (core) st2.push_back(val);
            else st1.push_back(val);
            if (rel) releaseCore(core);
            tb_tag = tb_tag + 5'd1;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        acc_seen      = 1'b0;
        for (int i = 0; i < 64 && !acc_seen; i++) cycle();
        if (!acc_seen) checkOutput("req_accept_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drainResults(input int maxc);
        bus.res_ready = 1'b1;
        for (int i = 0; i < maxc && exp_res.size() > 0; i++) cycle();
        if (exp_res.size() > 0) checkOutput("drain_timeout", exp_res.size(), 0);
        runCycles(2);
    endtask

    task automatic clearModel();
        exp_wr.delete();
        exp_res.delete();
        st1.delete();
        st2.delete();
        oq1.delete();
        oq2.delete();
        tb_tag    = '0;
        hold_pend = 1'b0;
        rd1_seen  = 1'b0;
        rd2_seen  = 1'b0;
        Out_Busy_Core1_Output = 1'b1;
        Out_Busy_Core2_Output = 1'b1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        In_Busy_Core1_Inp = 1'b0;
        In_Busy_Core1_Cmd = 1'b0;
        In_Busy_Core2_Inp = 1'b0;
        In_Busy_Core2_Cmd = 1'b0;
        clearModel();
        runCycles(2);
        rst_n = 1'b1;
        cycle();
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scenarios.
    initial begin
        int w0, e0, drop;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        In_Busy_Core1_Inp = 1'b0;
        In_Busy_Core1_Cmd = 1'b0;
        In_Busy_Core2_Inp = 1'b0;
        In_Busy_Core2_Cmd = 1'b0;
        Data_Out_Core1_Output = '0;
        Data_Out_Core2_Output = '0;
        clearModel();
        #1;
        checkOutput("rst_req_ready", bus.req_ready, 0);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_strobes", {wr_en_Core1_Inp, wr_en_Core1_Cmd, wr_en_Core2_Inp,
                    wr_en_Core2_Cmd, rd_en_Core1_Output, rd_en_Core2_Output, bus.req_err}, 0);
        checkOutput("rst_res_data", {bus.res_tag, bus.res_data}, 0);
        runCycles(2);
        rst_n = 1'b1;
        checkOutput("rst_ready_before_edge", bus.req_ready, 0);
        cycle();
        checkOutput("rst_ready_first_edge", bus.req_ready, 1);

        $display("[TB] Mul issue");
        resetDut();
        w0 = wr_cnt;
        applyStimulus(OP_MUL, 5, 3, 256'hABC, 0);
        runCycles(2);
        checkOutput("mul_write_count", wr_cnt - w0, 1);
        checkOutput("mul_latency", last_wr_cyc - acc_cyc, 2);
        checkOutput("mul_outstanding", outstanding, 1);
        releaseCore(0);
        drainResults(40);
        checkOutput("mul_outstanding_done", outstanding, 0);

        $display("[TB] Ordering");
        resetDut();
        applyStimulus(OP_SQR, 7, 9, 256'h22, 0);
        applyStimulus(OP_XOR, 256'h11, 256'h0F, 256'h11, 0);
        runCycles(3);
        releaseCore(0);
        runCycles(6);
        checkOutput("order_no_early_result", bus.res_valid, 0);
        checkOutput("order_outstanding", outstanding, 2);
        releaseCore(1);
        drainResults(40);

        $display("[TB] Backpressure");
        resetDut();
        In_Busy_Core2_Cmd = 1'b1;
        applyStimulus(OP_INV, 256'h33, 256'h44, 256'h55, 1);
        w0 = wr_cnt;
        runCycles(10);
        checkOutput("bp_no_write", wr_cnt - w0, 0);
        checkOutput("bp_not_ready", bus.req_ready, 0);
        In_Busy_Core2_Cmd = 1'b0;
        drop = cyc;
        for (int i = 0; i < 10 && wr_cnt == w0; i++) cycle();
        checkOutput("bp_write_delay", last_wr_cyc - drop, 1);
        drainResults(40);

        $display("[TB] Full queue and tag wrap");
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(OP_MUL, DATA'(i), DATA'(i + 1), DATA'(i * 3 + 1), 0);
        runCycles(3);
        checkOutput("full_outstanding", outstanding, 8);
        checkOutput("full_not_ready", bus.req_ready, 0);
        releaseCore(0);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 40 && exp_res.size() > 7; i++) cycle();
        bus.res_ready = 1'b0;
        checkOutput("full_pop_ready", bus.req_ready, 1);
        checkOutput("full_pop_outstanding", outstanding, 7);
        drainResults(100);
        bus.res_ready = 1'b1;
        for (int i = 8; i < 32; i++) begin
            applyStimulus((i % 2 == 0) ? OP_RED : OP_XOR, DATA'(i * 7), DATA'(i), DATA'(i + 100), 1);
            if (i == 20) checkOutput("issue_interval", acc_cyc - prev_acc_cyc, 3);
        end
        applyStimulus(OP_SQR, 256'h77, 256'h0, 256'h99, 1);
        runCycles(3);
        checkOutput("tag_wrap", last_cmd[7:3], 0);
        drainResults(100);

        $display("[TB] Illegal opcode");
        resetDut();
        w0 = wr_cnt;
        e0 = err_cnt;
        applyStimulus(3'd7, 256'h1, 256'h2, 256'h0, 0);
        runCycles(4);
        checkOutput("ill_err_pulses", err_cnt - e0, 1);
        checkOutput("ill_err_delay", err_cyc - acc_cyc, 1);
        checkOutput("ill_no_write", wr_cnt - w0, 0);
        checkOutput("ill_outstanding", outstanding, 0);
        applyStimulus(3'd0, 256'h1, 256'h2, 256'h0, 0);
        runCycles(2);
        applyStimulus(OP_MUL, 256'h1, 256'h2, 256'h4, 1);
        drainResults(40);

        $display("[TB] Reset in WAIT");
        resetDut();
        In_Busy_Core1_Inp = 1'b1;
        applyStimulus(OP_MUL, 256'hAA, 256'hBB, 256'hCC, 0);
        runCycles(2);
        w0 = wr_cnt;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstw_req_ready", bus.req_ready, 0);
        checkOutput("rstw_wr_en", {wr_en_Core1_Inp, wr_en_Core1_Cmd}, 0);
        checkOutput("rstw_outstanding", outstanding, 0);
        clearModel();
        In_Busy_Core1_Inp = 1'b0;
        runCycles(2);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        runCycles(8);
        checkOutput("rstw_no_replay", wr_cnt - w0, 0);

        $display("[TB] Reset in HOLD");
        resetDut();
        applyStimulus(OP_MUL, 256'h12, 256'h34, 256'h5678, 1);
        for (int i = 0; i < 30 && !bus.res_valid; i++) cycle();
        checkOutput("rsth_valid_before", bus.res_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rsth_res_valid", bus.res_valid, 0);
        checkOutput("rsth_res_data", {bus.res_tag, bus.res_data}, 0);
        checkOutput("rsth_outstanding", outstanding, 0);
        clearModel();
        runCycles(2);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        runCycles(8);
        checkOutput("rsth_no_stale_valid", bus.res_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_dispatch_scheduler.md
CORE_DISPATCH_SCHEDULER -- requirements
Module: core_dispatch_scheduler

Interface
REQ-001 SHALL have parameter DATA, default 256, operand/result width in bits.
REQ-002 SHALL have parameter ORD_DEPTH, default 8, maximum outstanding operations (power of two).
REQ-003 SHALL have clk input 1: the single clock; all logic rises on posedge clk.
REQ-004 SHALL have rst_n input 1: reset, asynchronous and active-low.
REQ-005 SHALL have req_valid input 1 and req_ready output 1: request handshake.
REQ-006 SHALL have req_op input 3: Mul=1, Sqr=2, Inv=3, Xor=4, Red=5.
REQ-007 SHALL have req_a input DATA and req_b input DATA: operands.
REQ-008 SHALL have req_err output 1: one-cycle pulse on an illegal opcode.
REQ-009 SHALL have wr_en_Core1_Inp output 1, Data_in_Core1_Inp output 2*DATA, and In_Busy_Core1_Inp input 1 (full).
REQ-010 SHALL have wr_en_Core1_Cmd output 1, Data_in_Core1_Cmd output 8, and In_Busy_Core1_Cmd input 1 (full).
REQ-011 SHALL have rd_en_Core1_Output output 1, Data_Out_Core1_Output input DATA, and Out_Busy_Core1_Output input 1 (empty).
REQ-012 SHALL have identical Core2 ports, except Data_in_Core2_Inp is DATA wide.
REQ-013 SHALL have res_valid output 1, res_ready input 1, res_data output DATA, and res_tag output 5.
REQ-014 SHALL have outstanding output 4: count of issued-but-unreturned operations.

Function
REQ-015 SHALL use the issue FSM states IDLE, WAIT, and WR.
REQ-016 SHALL drive req_ready=1 only in IDLE and only while outstanding<ORD_DEPTH.
REQ-017 SHALL, on accept (IDLE, req_valid & req_ready), latch op/a/b, go to WAIT, and assign a tag from the 5-bit tag counter.
REQ-018 SHALL route Mul and Xor to Core1 with Data_in_Core1_Inp={a,b}.
REQ-019 SHALL route Sqr, Inv, and Red to Core2 with Data_in_Core2_Inp=a; b is ignored.
REQ-020 SHALL, for req_op in {0,6,7}: accept the request, pulse req_err the next cycle, stay in IDLE, leave the tag unchanged, and issue nothing.
REQ-021 SHALL leave WAIT for WR only when the selected core's Inp and Cmd busy flags are both low in the same cycle, and otherwise hold indefinitely.
REQ-022 SHALL, in WR (exactly one cycle): pulse wr_en_*_Inp and wr_en_*_Cmd together, set Cmd byte={tag[4:0],op[2:0]}, push the core id to the order queue, increment the tag (31 wraps to 0), and return to IDLE.
REQ-023 SHALL give minimum issue throughput of one operation per 3 cycles; the accept-to-write latency is 2 cycles when the FIFOs are not busy.
REQ-024 SHALL keep the order queue at ORD_DEPTH entries of {core id, tag}, returning results strictly in issue order.
REQ-025 SHALL use the return FSM states RIDLE, RD, and HOLD.
REQ-026 SHALL, in RIDLE, enter RD when the queue is non-empty and the head core's Out_Busy is low.
REQ-027 SHALL, in RD, pulse rd_en of the head core for one cycle.
REQ-028 SHALL, in HOLD, capture the head core's Data_Out into res_data (FIFO read latency 1), set res_tag=head tag, and assert res_valid.
REQ-029 SHALL hold res_data/res_tag stable while res_valid & !res_ready.
REQ-030 SHALL, on res_valid & res_ready: pop the queue, deassert res_valid the next cycle, and return to RIDLE.
REQ-031 SHALL never read a non-head core even if that core has data ready; head-of-line blocking is required.
REQ-032 SHALL update outstanding as +1 on WR and -1 on pop; a simultaneous push and pop leaves it unchanged; it never exceeds ORD_DEPTH or underflows.
REQ-033 SHALL never assert both Core1 and Core2 write enables in the same cycle.

Reset
REQ-034 SHALL, on rst_n low at any time: return the FSMs to IDLE/RIDLE; clear the tag, queue pointers, and outstanding; and drive all wr_en/rd_en, req_err, and res_valid to 0, req_ready to 0, and res_data/res_tag to 0.
REQ-035 SHALL, on reset mid-operation, drop any latched request and queue contents, and SHALL NOT replay them after reset.
REQ-036 SHALL drive req_ready=1 on the first clk edge after rst_n rises.

Verification
REQ-037 SHALL verify Mul: Mul, a=5, b=3, FIFOs idle -> after 2 cycles, one-cycle wr_en_Core1_Inp with data {5,3} and Cmd=0x01, tag 0, outstanding=1.
REQ-038 SHALL verify ordering: Sqr, then Xor; preload Core1 output before Core2 output -> Core2 result returned first with tag 0, Core1 result second with tag 1.
REQ-039 SHALL verify backpressure: In_Busy_Core2_Cmd=1 for 10 cycles during Inv -> FSM holds in WAIT, no wr_en, write occurs 1 cycle after busy drops.
REQ-040 SHALL verify the full queue and tag wrap: issue 8 ops with no returns -> req_ready=0; pop one -> req_ready=1; after 32 issues the tag wraps to 0.
REQ-041 SHALL verify an illegal opcode: req_op=7 -> req_err pulse 1 cycle, no FIFO write, tag unchanged.
REQ-042 SHALL verify reset mid-operation: assert rst_n=0 in WAIT and HOLD -> all outputs 0 asynchronously, outstanding=0, no stale res_valid afterward.
